// File: rtl/mux_sel_ctrl_pkg.sv
// Shared types and constants for the mux channel-select controller.
// Holds the FSM state encoding and the channel-count and select-width constants.
package mux_ctrl_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        PAUSED = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_sel_ctrl_if.sv
// Bundles the controller's switch inputs and select outputs.
// A bench or parent uses it to carry the controller's pins.
interface mux_sel_ctrl_if;
    import mux_ctrl_pkg::*;

    logic              sw_1;
    logic              sw_2;
    logic              sw_3;
    logic              sw_4;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] onehot;
    logic              auto_mode;
    logic              strobe;

    modport master (
        output sw_1, sw_2, sw_3, sw_4,
        input  sel, onehot, auto_mode, strobe
    );

    modport slave (
        input  sw_1, sw_2, sw_3, sw_4,
        output sel, onehot, auto_mode, strobe
    );

endinterface

// File: rtl/mux_sel_ctrl_sw_edge_det.sv
// Rising-edge detector for one debounced switch level.
// Both sample stages reset high, so a switch held at reset release raises no event.
module sw_edge_det (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sw,
    output logic o_Event
);

    logic sw_q;
    logic sw_prev;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sw_q    <= 1'b1;
            sw_prev <= 1'b1;
        end else begin
            sw_q    <= i_Sw;
            sw_prev <= sw_q;
        end
    end

    assign o_Event = sw_q & ~sw_prev;

endmodule

// File: rtl/mux_sel_ctrl.sv
// Mux channel-select controller: manual next/prev stepping plus an auto-scan
// mode with pause; the dwell counter runs only while staying in AUTO.
module mux_sel_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_STEP = 25000000,
    parameter int unsigned NUM_CH        = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Switch_1,
    input  logic              i_Switch_2,
    input  logic              i_Switch_3,
    input  logic              i_Switch_4,
    output logic [SEL_W-1:0]  o_Sel,
    output logic [NUM_CH-1:0] o_Sel_Onehot,
    output logic              o_Auto,
    output logic              o_Sel_Strobe
);

    localparam int unsigned     CNT_W    = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_STEP - 1);

    logic [3:0]       ev;
    logic             step_ev;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] sel_nxt;

    sw_edge_det u_edge_1 (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Sw(i_Switch_1), .o_Event(ev[0]));
    sw_edge_det u_edge_2 (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Sw(i_Switch_2), .o_Event(ev[1]));
    sw_edge_det u_edge_3 (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Sw(i_Switch_3), .o_Event(ev[2]));
    sw_edge_det u_edge_4 (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Sw(i_Switch_4), .o_Event(ev[3]));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= MANUAL;
            cnt          <= '0;
            o_Sel        <= '0;
            o_Sel_Strobe <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            o_Sel        <= sel_nxt;
            o_Sel_Strobe <= (sel_nxt != o_Sel);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = o_Sel;
        step_ev   = ev[0] | ev[1];

        // Switch_3 outranks Switch_4; a Switch_4 event in MANUAL is dropped.
        if (ev[2]) begin
            state_nxt = (state == MANUAL) ? AUTO : MANUAL;
        end else if (ev[3]) begin
            case (state)
                AUTO:    state_nxt = PAUSED;
                PAUSED:  state_nxt = AUTO;
                MANUAL:  state_nxt = MANUAL;
                default: state_nxt = MANUAL;
            endcase
        end

        if (ev[0] && !ev[1]) begin
            sel_nxt = o_Sel + 1'b1;
        end else if (ev[1] && !ev[0]) begin
            sel_nxt = o_Sel - 1'b1;
        end

        // A manual step beats a coincident terminal count; leaving AUTO freezes the count.
        case (state)
            MANUAL: cnt_nxt = '0;
            AUTO: begin
                if (step_ev) begin
                    cnt_nxt = '0;
                end else if (state_nxt == AUTO) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        sel_nxt = o_Sel + 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: cnt_nxt = cnt;
        endcase
    end

    assign o_Auto       = (state != MANUAL);
    assign o_Sel_Onehot = sel_onehot(o_Sel);

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Scoreboard bench for mux_sel_ctrl: stimulus pushes expected outputs from a
// behavioural model each cycle, a monitor pops and compares at the falling edge.
module tb_mux_sel_ctrl;

    localparam int STEP = 4;
    localparam int MAN  = 0;
    localparam int AUT  = 1;
    localparam int PAU  = 2;

    typedef struct {
        int    sel;
        int    auto_on;
        int    strobe;
        string tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mux_sel_ctrl_if bus ();

    always #5 clk = ~clk;

    mux_sel_ctrl #(
        .CLKS_PER_STEP(STEP),
        .NUM_CH       (4)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Switch_1  (bus.sw_1),
        .i_Switch_2  (bus.sw_2),
        .i_Switch_3  (bus.sw_3),
        .i_Switch_4  (bus.sw_4),
        .o_Sel       (bus.sel),
        .o_Sel_Onehot(bus.onehot),
        .o_Auto      (bus.auto_mode),
        .o_Sel_Strobe(bus.strobe)
    );

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Model: mode, channel, dwell progress, and the last two switch samples.
    int         m_mode;
    int         m_sel;
    int         m_cnt;
    int         m_strobe;
    logic [3:0] s_cur;
    logic [3:0] s_prev;
    logic [3:0] sw_drv = '0;
    string      phase  = "init";

    function void check(input string name, input int act, input int exp, input string tag);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s [%s] at %0t: got %0d expected %0d", name, tag, $time, act, exp);
        end
    endfunction

    function void model_reset();
        m_mode   = MAN;
        m_sel    = 0;
        m_cnt    = 0;
        m_strobe = 0;
        s_cur    = '1;
        s_prev   = '1;
    endfunction

    function void model_edge();
        logic [3:0] ev;
        int         old_mode;
        int         new_sel;
        ev       = s_cur & ~s_prev;
        old_mode = m_mode;
        if (ev[2])
            m_mode = (m_mode == MAN) ? AUT : MAN;
        else if (ev[3] && m_mode != MAN)
            m_mode = (m_mode == AUT) ? PAU : AUT;
        new_sel = (m_sel + int'(ev[0]) - int'(ev[1]) + 4) % 4;
        if (old_mode == MAN) begin
            m_cnt = 0;
        end else if (old_mode == AUT) begin
            if (ev[0] || ev[1]) begin
                m_cnt = 0;
            end else if (m_mode == AUT) begin
                m_cnt++;
                if (m_cnt == STEP) begin
                    m_cnt   = 0;
                    new_sel = (new_sel + 1) % 4;
                end
            end
        end
        m_strobe = (new_sel != m_sel) ? 1 : 0;
        m_sel    = new_sel;
        s_prev   = s_cur;
        s_cur    = sw_drv;
    endfunction

    task automatic cycle(input logic [3:0] sw, input bit rst);
        exp_t e;
        @(posedge clk);
        if (rst_n) model_edge();
        #2;
        rst_n    = !rst;
        sw_drv   = sw;
        bus.sw_1 = sw[0];
        bus.sw_2 = sw[1];
        bus.sw_3 = sw[2];
        bus.sw_4 = sw[3];
        if (rst) model_reset();
        e.sel     = m_sel;
        e.auto_on = (m_mode != MAN) ? 1 : 0;
        e.strobe  = m_strobe;
        e.tag     = phase;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(4'b0000, 1'b0);
    endtask

    task automatic pulse(input logic [3:0] sw);
        cycle(sw, 1'b0);
        cycle(4'b0000, 1'b0);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t       e;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                oh = 4'b0001 << e.sel;
                check("sel",    int'(bus.sel),       e.sel,     e.tag);
                check("onehot", int'(bus.onehot),    int'(oh),  e.tag);
                check("auto",   int'(bus.auto_mode), e.auto_on, e.tag);
                check("strobe", int'(bus.strobe),    e.strobe,  e.tag);
            end
        end
    end

    initial begin
        logic [3:0] lvl;
        int         dens;
        model_reset();
        bus.sw_1 = 1'b0;
        bus.sw_2 = 1'b0;
        bus.sw_3 = 1'b0;
        bus.sw_4 = 1'b0;

        phase = "reset";
        repeat (3) cycle(4'b0000, 1'b1);

        phase = "next_x5";
        idle(2);
        repeat (5) begin
            pulse(4'b0001);
            idle(1);
        end

        phase = "prev_wrap";
        pulse(4'b0010);
        pulse(4'b0010);
        idle(2);
        phase = "cancel";
        pulse(4'b0011);
        idle(3);

        phase = "auto_scan";
        pulse(4'b0100);
        idle(14);

        phase = "pause";
        pulse(4'b1000);
        idle(10);
        pulse(4'b1000);
        idle(8);

        phase = "manual_vs_tc";
        for (int g = 0; g < 7; g++) begin
            pulse(4'b0001);
            idle(g);
        end
        idle(4);

        phase = "hold_across_reset";
        pulse(4'b0100);
        cycle(4'b0001, 1'b1);
        cycle(4'b0001, 1'b1);
        repeat (3) cycle(4'b0001, 1'b0);
        idle(2);

        phase = "reset_mid_dwell";
        pulse(4'b0100);
        idle(5);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        idle(6);

        phase = "random";
        lvl = '0;
        for (int b = 0; b < 15; b++) begin
            dens = 1 + (b % 6);
            for (int c = 0; c < 200; c++) begin
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 31) < dens) lvl[k] = ~lvl[k];
                cycle(lvl, ($urandom_range(0, 399) == 0));
            end
        end

        phase = "drain";
        idle(3);
        @(negedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0, phase);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
